// File: rtl/gol_sequencer.sv
// gol_sequencer: load / run / read job controller for a serially loaded
// Game-of-Life cell array.
// A job shifts N pattern bits into the array, steps it for a latched number
// of generations, then shifts the N cell states back out.
// Optional feature: define GOL_SEQ_RECIRC_EN to recirculate the array during
// readback, so that the array still holds its pattern after READ. When the
// macro is undefined, zeros are shifted in and the array is left all-dead.
module gol_sequencer #(
    parameter int rows    = 10,
    parameter int columns = 10,
    parameter int GEN_W   = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [GEN_W-1:0] gens,
    input  logic             in_valid,
    input  logic             in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             Shift,
    output logic             NextTimeTick,
    output logic             DataIn,
    input  logic             DataOut
);

    localparam int N     = rows * columns;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        READ = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] bitcnt;
    logic [GEN_W-1:0] gencnt;
    logic             last_bit;
    logic             in_hs;
    logic             out_hs;

    assign last_bit = (bitcnt == CNT_W'(N - 1));
    assign in_hs    = (state == LOAD) && in_valid;
    assign out_hs   = (state == READ) && out_ready;

    // State register; reset forces IDLE from any state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and array/handshake outputs.
    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = 1'b0;
        Shift        = 1'b0;
        NextTimeTick = 1'b0;
        DataIn       = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                Shift    = in_valid;
                DataIn   = in_data;
                if (in_valid && last_bit) begin
                    // A zero generation count skips RUN entirely.
                    state_nxt = (gencnt == '0) ? READ : RUN;
                end
            end
            RUN: begin
                // RUN is only entered with gencnt >= 1, so this ticks exactly
                // the latched number of generations.
                NextTimeTick = (gencnt != '0);
                if (gencnt <= GEN_W'(1)) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                out_valid = 1'b1;
                out_data  = DataOut;
                Shift     = out_ready;
`ifdef GOL_SEQ_RECIRC_EN
                DataIn    = DataOut;
`else
                DataIn    = 1'b0;
`endif
                if (out_ready && last_bit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit and generation counters; both advance only on real handshakes/ticks.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bitcnt <= '0;
            gencnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bitcnt <= '0;
                    if (start) begin
                        gencnt <= gens;
                    end
                end
                LOAD: begin
                    if (in_hs) begin
                        bitcnt <= last_bit ? '0 : bitcnt + 1'b1;
                    end
                end
                RUN: begin
                    if (gencnt != '0) begin
                        gencnt <= gencnt - 1'b1;
                    end
                end
                READ: begin
                    if (out_hs) begin
                        bitcnt <= last_bit ? '0 : bitcnt + 1'b1;
                    end
                end
                default: bitcnt <= '0;
            endcase
        end
    end

    // Completion pulse in the cycle after the final readback handshake.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            done <= 1'b0;
        end else begin
            done <= out_hs && last_bit;
        end
    end

endmodule
